// File: rtl/branch_tracker_if.sv
// Bundle of fetch, commit and predictor-training signals around branch_tracker.
// master is the fetch/commit/predictor side; slave is the tracker itself.
interface branch_tracker_if #(
  parameter int unsigned LOCAL_WIDTH = 6
);
  logic                   rdy_in;
  logic                   alloc_valid;
  logic [31:0]            alloc_pc;
  logic [31:0]            alloc_target;
  logic                   alloc_prediction;
  logic [1:0]             alloc_selection;
  logic                   alloc_ready;
  logic                   resolve_valid;
  logic                   resolve_taken;
  logic                   resolve_ready;
  logic                   transition_signal;
  logic [LOCAL_WIDTH-1:0] transition_addr;
  logic [1:0]             transition_selection;
  logic                   branch;
  logic                   mispredict_valid;
  logic [31:0]            mispredict_pc;
  logic [31:0]            branch_count;
  logic [31:0]            miss_count;

  modport master (
    output rdy_in, alloc_valid, alloc_pc, alloc_target, alloc_prediction, alloc_selection,
    output resolve_valid, resolve_taken,
    input  alloc_ready, resolve_ready, transition_signal, transition_addr,
    input  transition_selection, branch, mispredict_valid, mispredict_pc,
    input  branch_count, miss_count
  );

  modport slave (
    input  rdy_in, alloc_valid, alloc_pc, alloc_target, alloc_prediction, alloc_selection,
    input  resolve_valid, resolve_taken,
    output alloc_ready, resolve_ready, transition_signal, transition_addr,
    output transition_selection, branch, mispredict_valid, mispredict_pc,
    output branch_count, miss_count
  );
endinterface

// File: rtl/branch_tracker.sv
// In-order queue of predicted conditional branches; trains the predictor on resolve and
// issues a redirect plus wrong-path flush on a misprediction.
module branch_tracker #(
  parameter int unsigned LOCAL_WIDTH = 6,
  parameter int unsigned DEPTH_WIDTH = 3
) (
  input logic             clk_in,
  input logic             rst_in,
  branch_tracker_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_WIDTH;

  typedef logic [DEPTH_WIDTH-1:0] ptr_t;
  typedef logic [DEPTH_WIDTH:0]   cnt_t;

  // Entry storage; contents are don't-care after reset so no reset is applied.
  logic [31:0] pc_mem     [Depth];
  logic [31:0] target_mem [Depth];
  logic        pred_mem   [Depth];
  logic [1:0]  sel_mem    [Depth];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic                   trans_sig_q, trans_sig_d;
  logic [LOCAL_WIDTH-1:0] trans_addr_q, trans_addr_d;
  logic [1:0]             trans_sel_q, trans_sel_d;
  logic                   branch_q, branch_d;
  logic                   mis_valid_q, mis_valid_d;
  logic [31:0]            mis_pc_q, mis_pc_d;
  logic [31:0]            branch_count_q, branch_count_d;
  logic [31:0]            miss_count_q, miss_count_d;

  logic        not_full;
  logic        not_empty;
  logic        pop;
  logic        flush;
  logic        push;
  logic [31:0] head_pc;
  logic [31:0] head_target;
  logic        head_pred;
  logic [1:0]  head_sel;

  assign not_full  = (count_q != cnt_t'(Depth));
  assign not_empty = (count_q != '0);

  assign head_pc     = pc_mem[head_q];
  assign head_target = target_mem[head_q];
  assign head_pred   = pred_mem[head_q];
  assign head_sel    = sel_mem[head_q];

  assign pop   = bus.resolve_valid & not_empty & bus.rdy_in;
  assign flush = pop & (bus.resolve_taken != head_pred);
  // A flush kills everything younger, including a branch arriving in the same cycle.
  assign push  = bus.alloc_valid & not_full & bus.rdy_in & ~flush;

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    trans_sig_d    = 1'b0;
    trans_addr_d   = trans_addr_q;
    trans_sel_d    = trans_sel_q;
    branch_d       = branch_q;
    mis_valid_d    = 1'b0;
    mis_pc_d       = mis_pc_q;
    branch_count_d = branch_count_q;
    miss_count_d   = miss_count_q;

    if (pop) begin
      trans_sig_d    = 1'b1;
      trans_addr_d   = head_pc[LOCAL_WIDTH+1:2];
      trans_sel_d    = head_sel;
      branch_d       = bus.resolve_taken;
      branch_count_d = branch_count_q + 32'd1;
    end

    if (flush) begin
      mis_valid_d  = 1'b1;
      mis_pc_d     = bus.resolve_taken ? head_target : head_pc + 32'd4;
      miss_count_d = miss_count_q + 32'd1;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
    end else begin
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      if (push) begin
        tail_d = tail_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      trans_sig_q    <= 1'b0;
      trans_addr_q   <= '0;
      trans_sel_q    <= '0;
      branch_q       <= 1'b0;
      mis_valid_q    <= 1'b0;
      mis_pc_q       <= '0;
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      trans_sig_q    <= trans_sig_d;
      trans_addr_q   <= trans_addr_d;
      trans_sel_q    <= trans_sel_d;
      branch_q       <= branch_d;
      mis_valid_q    <= mis_valid_d;
      mis_pc_q       <= mis_pc_d;
      branch_count_q <= branch_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[tail_q]     <= bus.alloc_pc;
      target_mem[tail_q] <= bus.alloc_target;
      pred_mem[tail_q]   <= bus.alloc_prediction;
      sel_mem[tail_q]    <= bus.alloc_selection;
    end
  end

  assign bus.alloc_ready          = not_full;
  assign bus.resolve_ready        = not_empty;
  assign bus.transition_signal    = trans_sig_q;
  assign bus.transition_addr      = trans_addr_q;
  assign bus.transition_selection = trans_sel_q;
  assign bus.branch               = branch_q;
  assign bus.mispredict_valid     = mis_valid_q;
  assign bus.mispredict_pc        = mis_pc_q;
  assign bus.branch_count         = branch_count_q;
  assign bus.miss_count           = miss_count_q;

  // Pointer distance must always agree with the occupancy counter.
  count_bounded: assert property (@(posedge clk_in) disable iff (!rst_in)
    count_q <= cnt_t'(Depth));
  ptr_consistent: assert property (@(posedge clk_in) disable iff (!rst_in)
    ptr_t'(tail_q - head_q) == count_q[DEPTH_WIDTH-1:0]);

endmodule

// File: tb/tb_branch_tracker.sv
// Self-checking bench for branch_tracker: directed vector table, corner-case sequences
// and random traffic compared against a queue-based reference model.
module tb_branch_tracker;

  localparam int unsigned LW    = 6;
  localparam int unsigned DW    = 3;
  localparam int unsigned Depth = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  branch_tracker_if #(.LOCAL_WIDTH(LW)) bus ();

  branch_tracker #(
    .LOCAL_WIDTH(LW),
    .DEPTH_WIDTH(DW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic [1:0]  sel;
  } ent_t;

  ent_t        mq[$];
  logic        m_ts, m_branch, m_mv;
  logic [5:0]  m_addr;
  logic [1:0]  m_sel;
  logic [31:0] m_mpc, m_bc, m_mc;

  typedef struct {
    logic        av;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic [1:0]  sel;
    logic        rv;
    logic        taken;
    logic        e_ts;
    logic [5:0]  e_addr;
    logic        e_mv;
    logic [31:0] e_mpc;
    logic        e_ar;
    logic        e_rr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_branch = 0; m_mv = 0; m_addr = '0; m_sel = '0;
    m_mpc = '0; m_bc = '0; m_mc = '0;
  endtask

  task automatic model_step(input logic rdy, av, input logic [31:0] pc, tgt,
                            input logic pred, input logic [1:0] sel, input logic rv, taken);
    bit   full;
    bit   fl;
    ent_t e;
    ent_t n;
    full = (mq.size() == Depth);
    fl   = 0;
    m_ts = 0;
    m_mv = 0;
    if (rdy && rv && mq.size() > 0) begin
      e        = mq.pop_front();
      m_ts     = 1;
      m_addr   = 6'((e.pc / 4) % (1 << LW));
      m_sel    = e.sel;
      m_branch = taken;
      m_bc     = m_bc + 1;
      if (taken != e.pred) begin
        fl    = 1;
        m_mv  = 1;
        m_mpc = taken ? e.tgt : e.pc + 32'd4;
        m_mc  = m_mc + 1;
        mq.delete();
      end
    end
    if (rdy && av && !full && !fl) begin
      n.pc = pc; n.tgt = tgt; n.pred = pred; n.sel = sel;
      mq.push_back(n);
    end
  endtask

  task automatic check_model();
    chk("transition_signal", 32'(bus.transition_signal), 32'(m_ts));
    chk("transition_addr", 32'(bus.transition_addr), 32'(m_addr));
    chk("transition_selection", 32'(bus.transition_selection), 32'(m_sel));
    chk("branch", 32'(bus.branch), 32'(m_branch));
    chk("mispredict_valid", 32'(bus.mispredict_valid), 32'(m_mv));
    chk("mispredict_pc", bus.mispredict_pc, m_mpc);
    chk("branch_count", bus.branch_count, m_bc);
    chk("miss_count", bus.miss_count, m_mc);
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() != Depth));
    chk("resolve_ready", 32'(bus.resolve_ready), 32'(mq.size() != 0));
  endtask

  task automatic set_idle();
    bus.rdy_in = 1'b1; bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_target = '0;
    bus.alloc_prediction = 1'b0; bus.alloc_selection = '0;
    bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
  endtask

  task automatic drive_cycle(input logic rdy, av, input logic [31:0] pc, tgt,
                             input logic pred, input logic [1:0] sel, input logic rv, taken);
    bus.rdy_in = rdy; bus.alloc_valid = av; bus.alloc_pc = pc; bus.alloc_target = tgt;
    bus.alloc_prediction = pred; bus.alloc_selection = sel;
    bus.resolve_valid = rv; bus.resolve_taken = taken;
    model_step(rdy, av, pc, tgt, pred, sel, rv, taken);
    @(posedge clk_in);
    #1;
    check_model();
  endtask

  task automatic alloc(input logic [31:0] pc, tgt, input logic pred, input logic [1:0] sel);
    drive_cycle(1'b1, 1'b1, pc, tgt, pred, sel, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic taken);
    drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, taken);
  endtask

  function automatic vec_t mk(input logic av, input logic [31:0] pc, tgt, input logic pred,
                              input logic [1:0] sel, input logic rv, taken, input logic e_ts,
                              input logic [5:0] e_addr, input logic e_mv,
                              input logic [31:0] e_mpc, input logic e_ar, e_rr);
    vec_t v;
    v.av = av; v.pc = pc; v.tgt = tgt; v.pred = pred; v.sel = sel; v.rv = rv;
    v.taken = taken; v.e_ts = e_ts; v.e_addr = e_addr; v.e_mv = e_mv; v.e_mpc = e_mpc;
    v.e_ar = e_ar; v.e_rr = e_rr;
    return v;
  endfunction

  initial begin
    set_idle();
    bus.rdy_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_model();
    chk("reset alloc_ready", 32'(bus.alloc_ready), 32'd1);
    rst_in = 1'b1;

    // Fill and drain, then a mispredict redirect
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b1, 32'h1000 + 32'(4 * i), 32'h8000 + 32'(i), 1'b1, 2'(i), 1'b0, 1'b0,
                       1'b0, '0, 1'b0, '0, (i < 7), 1'b1));
    end
    tbl.push_back(mk(1'b1, 32'h1020, 32'h8008, 1'b1, 2'd0, 1'b0, 1'b0,
                     1'b0, '0, 1'b0, '0, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1,
                       1'b1, 6'(i), 1'b0, '0, 1'b1, (i < 7)));
    end
    tbl.push_back(mk(1'b1, 32'h2040, 32'h3000, 1'b1, 2'd2, 1'b0, 1'b0,
                     1'b0, '0, 1'b0, '0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 32'h2100, 32'h3100, 1'b0, 2'd1, 1'b0, 1'b0,
                     1'b0, '0, 1'b0, '0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 32'h2200, 32'h3200, 1'b1, 2'd3, 1'b0, 1'b0,
                     1'b0, '0, 1'b0, '0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0,
                     1'b1, 6'h10, 1'b1, 32'h2044, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0,
                     1'b0, '0, 1'b0, '0, 1'b1, 1'b0));

    foreach (tbl[k]) begin
      drive_cycle(1'b1, tbl[k].av, tbl[k].pc, tbl[k].tgt, tbl[k].pred, tbl[k].sel,
                  tbl[k].rv, tbl[k].taken);
      chk($sformatf("vec%0d transition_signal", k), 32'(bus.transition_signal),
          32'(tbl[k].e_ts));
      if (tbl[k].e_ts) begin
        chk($sformatf("vec%0d transition_addr", k), 32'(bus.transition_addr),
            32'(tbl[k].e_addr));
      end
      chk($sformatf("vec%0d mispredict_valid", k), 32'(bus.mispredict_valid),
          32'(tbl[k].e_mv));
      if (tbl[k].e_mv) begin
        chk($sformatf("vec%0d mispredict_pc", k), bus.mispredict_pc, tbl[k].e_mpc);
        chk($sformatf("vec%0d branch", k), 32'(bus.branch), 32'd0);
      end
      chk($sformatf("vec%0d alloc_ready", k), 32'(bus.alloc_ready), 32'(tbl[k].e_ar));
      chk($sformatf("vec%0d resolve_ready", k), 32'(bus.resolve_ready), 32'(tbl[k].e_rr));
    end
    chk("miss_count after redirect", bus.miss_count, 32'd1);
    chk("branch_count after redirect", bus.branch_count, 32'd9);

    // Flush wins over a same-cycle allocation
    alloc(32'h4000, 32'h4800, 1'b1, 2'd0);
    drive_cycle(1'b1, 1'b1, 32'h5000, 32'h5800, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("flush mispredict_pc", bus.mispredict_pc, 32'h4004);
    chk("flush empties queue", 32'(bus.resolve_ready), 32'd0);
    resolve(1'b1);
    chk("dropped alloc not resolvable", 32'(bus.transition_signal), 32'd0);

    // Concurrent allocate and pop at count 4 with tail wrap
    for (int i = 0; i < 4; i++) begin
      alloc(32'h7000 + 32'(4 * i), 32'h7800, 1'(i % 2), 2'(i));
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b1, 1'b1, 32'h7010 + 32'(4 * k), 32'h7900, 1'(k % 2), 2'(k), 1'b1,
                  1'(k % 2));
      chk("concurrent addr", 32'(bus.transition_addr), 32'(k));
      chk("concurrent count held", 32'(bus.resolve_ready && bus.alloc_ready), 32'd1);
    end
    for (int k = 8; k < 12; k++) begin
      resolve(1'(k % 2));
      chk("wrap drain addr", 32'(bus.transition_addr), 32'(k));
    end
    chk("wrap drained", 32'(bus.resolve_ready), 32'd0);

    // Stall holds a pending resolve
    alloc(32'h6014, 32'h6100, 1'b1, 2'd1);
    for (int s = 0; s < 3; s++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
      chk("stall no pulse", 32'(bus.transition_signal), 32'd0);
      chk("stall keeps entry", 32'(bus.resolve_ready), 32'd1);
    end
    resolve(1'b1);
    chk("stall release pulse", 32'(bus.transition_signal), 32'd1);
    chk("stall release addr", 32'(bus.transition_addr), 32'd5);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) begin
      alloc(32'h9000 + 32'(4 * i), 32'h9800, 1'b1, 2'd3);
    end
    resolve(1'b1);
    chk("pulse before reset", 32'(bus.transition_signal), 32'd1);
    set_idle();
    #3;
    rst_in = 1'b0;
    #1;
    chk("areset transition_signal", 32'(bus.transition_signal), 32'd0);
    chk("areset transition_selection", 32'(bus.transition_selection), 32'd0);
    chk("areset branch", 32'(bus.branch), 32'd0);
    chk("areset mispredict_pc", bus.mispredict_pc, 32'd0);
    chk("areset branch_count", bus.branch_count, 32'd0);
    chk("areset miss_count", bus.miss_count, 32'd0);
    chk("areset alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("areset resolve_ready", 32'(bus.resolve_ready), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    check_model();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic        rdy, av, pred, rv, taken;
      logic [1:0]  sel;
      logic [31:0] pc, tgt;
      rdy  = ($urandom_range(3) != 0);
      av   = ($urandom_range(9) < 6);
      pc   = $urandom;
      if ($urandom_range(15) == 0) pc = 32'hFFFF_FFFC;
      tgt  = $urandom;
      pred = 1'($urandom_range(1));
      sel  = 2'($urandom_range(3));
      rv   = 1'($urandom_range(1));
      if (mq.size() != 0 && $urandom_range(7) != 0) taken = mq[0].pred;
      else taken = 1'($urandom_range(1));
      drive_cycle(rdy, av, pc, tgt, pred, sel, rv, taken);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
